// File: rtl/arm7tdmi_tap_controller.sv
// rtl/arm7tdmi_tap_controller.sv - IEEE 1149.1 TAP controller for the ARM7TDMI debug port
// Owns IR, bypass, IDCODE and SCAN_N registers; muxes TDO with the selected scan chain.
module arm7tdmi_tap_controller #(
   parameter logic [31:0] IDCODE_VAL = 32'h3F0F0F0F,
   parameter logic [3:0]  IR_RESET   = 4'b1110
) (
   input  logic       tck,
   input  logic       trst,
   input  logic       tms,
   input  logic       tdi,
   input  logic       chain_tdo,
   output logic       tdo,
   output logic       tdo_en,
   output logic [3:0] tap_state,
   output logic       capture_dr,
   output logic       shift_dr,
   output logic       update_dr,
   output logic       scan_n_select,
   output logic [3:0] scan_chain_id,
   output logic [3:0] instr,
   output logic       intest_sel,
   output logic       extest_sel,
   output logic       restart_req
);

   typedef enum logic [3:0] {
      TLR    = 4'hF, RTI    = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6,
      SH_DR  = 4'h2, EX1_DR = 4'h1, PAU_DR = 4'h3, EX2_DR = 4'h0,
      UPD_DR = 4'h5, SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA,
      EX1_IR = 4'h9, PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
   } tap_state_e;

   localparam logic [3:0] I_EXTEST  = 4'b0000;
   localparam logic [3:0] I_SCAN_N  = 4'b0010;
   localparam logic [3:0] I_RESTART = 4'b0100;
   localparam logic [3:0] I_INTEST  = 4'b1100;
   localparam logic [3:0] I_IDCODE  = 4'b1110;

   tap_state_e  state_q, state_d;
   logic [3:0]  instr_q, instr_d;
   logic [3:0]  ir_shift_q, ir_shift_d;
   logic [3:0]  scan_n_q, scan_n_d;
   logic        bypass_q, bypass_d;
   logic [31:0] id_shift_q, id_shift_d;
   logic        restart_q, restart_d;

   logic sel_idcode, sel_scan_n, sel_chain, sel_bypass;

   always_comb begin
      sel_idcode = (instr_q == I_IDCODE);
      sel_scan_n = (instr_q == I_SCAN_N);
      case (instr_q)
         4'b0000, 4'b0011, 4'b0100, 4'b0101,
         4'b0111, 4'b1001, 4'b1100: sel_chain = 1'b1;
         default:                   sel_chain = 1'b0;
      endcase
      // Unlisted instruction codes fall back to the bypass register.
      sel_bypass = !(sel_idcode || sel_scan_n || sel_chain);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         TLR:     state_d = tms ? TLR    : RTI;
         RTI:     state_d = tms ? SEL_DR : RTI;
         SEL_DR:  state_d = tms ? SEL_IR : CAP_DR;
         CAP_DR:  state_d = tms ? EX1_DR : SH_DR;
         SH_DR:   state_d = tms ? EX1_DR : SH_DR;
         EX1_DR:  state_d = tms ? UPD_DR : PAU_DR;
         PAU_DR:  state_d = tms ? EX2_DR : PAU_DR;
         EX2_DR:  state_d = tms ? UPD_DR : SH_DR;
         UPD_DR:  state_d = tms ? SEL_DR : RTI;
         SEL_IR:  state_d = tms ? TLR    : CAP_IR;
         CAP_IR:  state_d = tms ? EX1_IR : SH_IR;
         SH_IR:   state_d = tms ? EX1_IR : SH_IR;
         EX1_IR:  state_d = tms ? UPD_IR : PAU_IR;
         PAU_IR:  state_d = tms ? EX2_IR : PAU_IR;
         EX2_IR:  state_d = tms ? UPD_IR : SH_IR;
         UPD_IR:  state_d = tms ? SEL_DR : RTI;
         default: state_d = TLR;
      endcase
   end

   always_comb begin
      instr_d    = instr_q;
      ir_shift_d = ir_shift_q;
      scan_n_d   = scan_n_q;
      bypass_d   = bypass_q;
      id_shift_d = id_shift_q;

      if (state_q == TLR)    instr_d = IR_RESET;
      if (state_q == UPD_IR) instr_d = ir_shift_q;

      if (state_q == CAP_IR) ir_shift_d = 4'b0001;
      if (state_q == SH_IR)  ir_shift_d = {tdi, ir_shift_q[3:1]};

      if (state_q == CAP_DR) begin
         if (sel_idcode) id_shift_d = IDCODE_VAL;
         if (sel_scan_n) scan_n_d   = 4'b1000;
         if (sel_bypass) bypass_d   = 1'b0;
      end
      if (state_q == SH_DR) begin
         if (sel_idcode) id_shift_d = {tdi, id_shift_q[31:1]};
         if (sel_scan_n) scan_n_d   = {tdi, scan_n_q[3:1]};
         if (sel_bypass) bypass_d   = tdi;
      end

      // Pulse on entry to RTI only; instr_d covers the UpdIR edge that loads RESTART.
      restart_d = (state_d == RTI) && (state_q != RTI) && (instr_d == I_RESTART);
   end

   always_ff @(posedge tck) begin
      if (trst) begin
         state_q    <= TLR;
         instr_q    <= IR_RESET;
         ir_shift_q <= 4'b0001;
         scan_n_q   <= 4'b0000;
         bypass_q   <= 1'b0;
         id_shift_q <= IDCODE_VAL;
         restart_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         instr_q    <= instr_d;
         ir_shift_q <= ir_shift_d;
         scan_n_q   <= scan_n_d;
         bypass_q   <= bypass_d;
         id_shift_q <= id_shift_d;
         restart_q  <= restart_d;
      end
   end

   always_comb begin
      tdo = 1'b0;
      if (state_q == SH_IR) begin
         tdo = ir_shift_q[0];
      end else if (state_q == SH_DR) begin
         if (sel_idcode)      tdo = id_shift_q[0];
         else if (sel_scan_n) tdo = scan_n_q[0];
         else if (sel_chain)  tdo = chain_tdo;
         else                 tdo = bypass_q;
      end
   end

   assign tdo_en        = (state_q == SH_IR) || (state_q == SH_DR);
   assign tap_state     = state_q;
   assign capture_dr    = (state_q == CAP_DR);
   assign shift_dr      = (state_q == SH_DR);
   assign update_dr     = (state_q == UPD_DR);
   assign scan_n_select = (instr_q == I_SCAN_N);
   assign scan_chain_id = scan_n_q;
   assign instr         = instr_q;
   assign intest_sel    = (instr_q == I_INTEST);
   assign extest_sel    = (instr_q == I_EXTEST);
   assign restart_req   = restart_q;

endmodule
